// File: rtl/eth_rx_ram_wr.sv
// eth_rx_ram_wr
// Receives a byte-wide Ethernet frame, packs it little-endian into 32-bit
// words for the frame RAM and then writes a four-word descriptor into the
// timestamp RAM. The descriptor holds the timestamp, the length and a
// sequence number. Once the frame is complete it raises ram_data_flag.
// The flag stays up until the reader pulses ram_data_flag_clr. Frames that
// arrive while the flag is up are dropped and counted in drop_cnt. So are
// errored, oversize and runt frames.
//
// Ports:
//   user_clk, user_reset         clock, asynchronous active-high reset
//   rx_dv, rx_data, rx_err       byte stream in (one frame per rx_dv run)
//   ts_in                        free-running 64-bit timestamp
//   ram_data_flag, ram_dat_len   frame-ready handshake and accepted length
//   ram_data_flag_clr            reader pulse: frame consumed
//   eth_ram_*                    frame RAM write port (byte address)
//   ts_ram_*                     descriptor RAM write port (byte address)
//   drop_cnt                     saturating dropped-frame counter
module eth_rx_ram_wr #(
    parameter int MAX_BYTES = 1536,
    parameter int MIN_BYTES = 14
) (
    input  logic        user_clk,
    input  logic        user_reset,
    input  logic        rx_dv,
    input  logic [7:0]  rx_data,
    input  logic        rx_err,
    input  logic [63:0] ts_in,
    output logic        ram_data_flag,
    input  logic        ram_data_flag_clr,
    output logic [10:0] ram_dat_len,
    output logic        eth_ram_en,
    output logic        eth_ram_we,
    output logic [10:0] eth_ram_add,
    output logic [31:0] eth_ram_dat,
    output logic        ts_ram_en,
    output logic        ts_ram_we,
    output logic [3:0]  ts_ram_add,
    output logic [31:0] ts_ram_dat,
    output logic [15:0] drop_cnt
);

    localparam logic [10:0] MAX_LEN = 11'(MAX_BYTES);
    localparam logic [10:0] MIN_LEN = 11'(MIN_BYTES);

    typedef enum logic [2:0] {IDLE, RECV, FLUSH, TS_WR, DROP} state_t;

    state_t      state_reg, state_next;
    logic [10:0] byte_cnt_reg;
    logic [8:0]  word_idx_reg;
    logic [31:0] word_buf_reg;
    logic [63:0] ts_cap_reg;
    logic [1:0]  ts_idx_reg;
    logic [15:0] seq_reg;
    logic        flag_reg;
    logic [10:0] len_reg;
    logic [15:0] drop_cnt_reg;
    logic        eth_en_reg;
    logic [10:0] eth_add_reg;
    logic [31:0] eth_dat_reg;

    logic        start_frame, take_byte, drop_frame, flush_word, frame_done;
    logic [1:0]  lane;

    assign lane = byte_cnt_reg[1:0];

    always_ff @(posedge user_clk or posedge user_reset) begin
        if (user_reset) state_reg <= IDLE;
        else            state_reg <= state_next;
    end

    always_comb begin
        state_next  = state_reg;
        start_frame = 1'b0;
        take_byte   = 1'b0;
        drop_frame  = 1'b0;
        flush_word  = 1'b0;
        frame_done  = 1'b0;
        case (state_reg)
            IDLE: begin
                // The flag is checked before a same-cycle clear takes effect,
                // so a frame that starts together with the clear pulse is still dropped.
                if (rx_dv) begin
                    if (flag_reg || rx_err) begin
                        state_next = DROP;
                        drop_frame = 1'b1;
                    end else begin
                        state_next  = RECV;
                        start_frame = 1'b1;
                    end
                end
            end
            RECV: begin
                if (rx_dv) begin
                    if (rx_err || byte_cnt_reg >= MAX_LEN) begin
                        state_next = DROP;
                        drop_frame = 1'b1;
                    end else begin
                        take_byte = 1'b1;
                    end
                end else if (byte_cnt_reg < MIN_LEN) begin
                    state_next = IDLE;
                    drop_frame = 1'b1;
                end else if (lane != 2'd0) begin
                    state_next = FLUSH;
                    flush_word = 1'b1;
                end else begin
                    state_next = TS_WR;
                end
            end
            FLUSH: begin
                if (rx_dv) begin
                    state_next = DROP;
                    drop_frame = 1'b1;
                end else begin
                    state_next = TS_WR;
                end
            end
            TS_WR: begin
                // A new frame arriving before the descriptor is done loses the old one.
                if (rx_dv) begin
                    state_next = DROP;
                    drop_frame = 1'b1;
                end else if (ts_idx_reg == 2'd3) begin
                    state_next = IDLE;
                    frame_done = 1'b1;
                end
            end
            DROP: begin
                if (!rx_dv) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge user_clk or posedge user_reset) begin
        if (user_reset) begin
            byte_cnt_reg <= '0;
            word_idx_reg <= '0;
            word_buf_reg <= '0;
            ts_cap_reg   <= '0;
            ts_idx_reg   <= '0;
            seq_reg      <= '0;
            flag_reg     <= 1'b0;
            len_reg      <= '0;
            drop_cnt_reg <= '0;
            eth_en_reg   <= 1'b0;
            eth_add_reg  <= '0;
            eth_dat_reg  <= '0;
        end else begin
            eth_en_reg <= 1'b0;

            if (start_frame) begin
                ts_cap_reg   <= ts_in;
                word_buf_reg <= {24'd0, rx_data};
                byte_cnt_reg <= 11'd1;
                word_idx_reg <= '0;
                ts_idx_reg   <= '0;
            end

            if (take_byte) begin
                byte_cnt_reg <= byte_cnt_reg + 11'd1;
                // Lane 0 reloads the whole buffer so a partial last word has zero padding.
                if (lane == 2'd0) word_buf_reg <= {24'd0, rx_data};
                else              word_buf_reg[{lane, 3'b000} +: 8] <= rx_data;
                if (lane == 2'd3) begin
                    eth_en_reg   <= 1'b1;
                    eth_add_reg  <= {word_idx_reg, 2'b00};
                    eth_dat_reg  <= {rx_data, word_buf_reg[23:0]};
                    word_idx_reg <= word_idx_reg + 9'd1;
                end
            end

            if (flush_word) begin
                eth_en_reg  <= 1'b1;
                eth_add_reg <= {word_idx_reg, 2'b00};
                eth_dat_reg <= word_buf_reg;
            end

            if (state_reg == TS_WR) ts_idx_reg <= ts_idx_reg + 2'd1;

            if (drop_frame && drop_cnt_reg != 16'hFFFF)
                drop_cnt_reg <= drop_cnt_reg + 16'd1;

            if (frame_done) begin
                flag_reg <= 1'b1;
                len_reg  <= byte_cnt_reg;
                seq_reg  <= seq_reg + 16'd1;
            end else if (flag_reg && ram_data_flag_clr) begin
                flag_reg <= 1'b0;
            end
        end
    end

    always_comb begin
        ts_ram_dat = '0;
        if (state_reg == TS_WR) begin
            case (ts_idx_reg)
                2'd0:    ts_ram_dat = ts_cap_reg[31:0];
                2'd1:    ts_ram_dat = ts_cap_reg[63:32];
                2'd2:    ts_ram_dat = {21'd0, byte_cnt_reg};
                default: ts_ram_dat = {seq_reg, 16'd0};
            endcase
        end
    end

    assign ts_ram_en     = (state_reg == TS_WR);
    assign ts_ram_we     = (state_reg == TS_WR);
    assign ts_ram_add    = {ts_idx_reg, 2'b00};
    assign eth_ram_en    = eth_en_reg;
    assign eth_ram_we    = eth_en_reg;
    assign eth_ram_add   = eth_add_reg;
    assign eth_ram_dat   = eth_dat_reg;
    assign ram_data_flag = flag_reg;
    assign ram_dat_len   = len_reg;
    assign drop_cnt      = drop_cnt_reg;

endmodule
